// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter. A grant is held until done; each grant may
// serve up to weight transactions before priority rotates past the winner.
module arbiter_wrr #(
  parameter int REQ_WIDTH = 8,
  parameter int WGT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [REQ_WIDTH-1:0]           req,
  input  logic [REQ_WIDTH*WGT_WIDTH-1:0] weight,
  input  logic                           done,
  output logic [REQ_WIDTH-1:0]           gnt,
  output logic [$clog2(REQ_WIDTH)-1:0]   gnt_id,
  output logic                           gnt_vld
);

  localparam int IDW = $clog2(REQ_WIDTH);

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t               state, state_n;
  logic [REQ_WIDTH-1:0] base, base_n;
  logic [WGT_WIDTH-1:0] credit, credit_n;
  logic [REQ_WIDTH-1:0] gnt_n;
  logic [IDW-1:0]       gnt_id_n;

  logic                   release_g;
  logic [REQ_WIDTH-1:0]   arb_base;
  logic [IDW-1:0]         arb_idx;
  logic [2*REQ_WIDTH-1:0] req_dbl;
  logic                   win_vld;
  logic [IDW-1:0]         win_id;
  logic [WGT_WIDTH-1:0]   win_wgt;
  int unsigned            sum;

  always_comb begin
    release_g = (state == GRANT) && done &&
                ((credit <= WGT_WIDTH'(1)) || !(|(req & gnt)));
    // On release, arbitrate this cycle against the rotated pointer so the
    // next winner is granted without an idle gap.
    arb_base = release_g ? {gnt[REQ_WIDTH-2:0], gnt[REQ_WIDTH-1]} : base;

    arb_idx = '0;
    for (int unsigned i = 0; i < REQ_WIDTH; i++)
      if (arb_base[i]) arb_idx = IDW'(i);

    // Doubled request vector shifted down by the pointer gives a wrap-around scan.
    req_dbl = {req, req} >> arb_idx;
    win_vld = 1'b0;
    win_id  = '0;
    sum     = 0;
    for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
      if (!win_vld && req_dbl[i]) begin
        win_vld = 1'b1;
        sum     = 32'(arb_idx) + i;
        win_id  = (sum >= REQ_WIDTH) ? IDW'(sum - REQ_WIDTH) : IDW'(sum);
      end
    end

    win_wgt = '0;
    for (int unsigned i = 0; i < REQ_WIDTH; i++)
      if (win_id == IDW'(i)) win_wgt = weight[i*WGT_WIDTH +: WGT_WIDTH];
    if (win_wgt == '0) win_wgt = WGT_WIDTH'(1);
  end

  always_comb begin
    state_n  = state;
    base_n   = base;
    credit_n = credit;
    gnt_n    = gnt;
    gnt_id_n = gnt_id;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_n         = GRANT;
          gnt_n           = '0;
          gnt_n[win_id]   = 1'b1;
          gnt_id_n        = win_id;
          credit_n        = win_wgt;
        end
      end
      GRANT: begin
        if (release_g) begin
          base_n = arb_base;
          if (win_vld) begin
            gnt_n         = '0;
            gnt_n[win_id] = 1'b1;
            gnt_id_n      = win_id;
            credit_n      = win_wgt;
          end else begin
            state_n  = IDLE;
            gnt_n    = '0;
            gnt_id_n = '0;
            credit_n = '0;
          end
        end else if (done) begin
          credit_n = credit - WGT_WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base   <= REQ_WIDTH'(1);
      credit <= '0;
      gnt    <= '0;
      gnt_id <= '0;
    end else begin
      state  <= state_n;
      base   <= base_n;
      credit <= credit_n;
      gnt    <= gnt_n;
      gnt_id <= gnt_id_n;
    end
  end

  assign gnt_vld = |gnt;

endmodule

// File: tb/tb_arbiter_wrr.sv
// Directed bench for arbiter_wrr at REQ_WIDTH=4, WGT_WIDTH=4.
module tb_arbiter_wrr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] weight;
  logic        done;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        gnt_vld;

  int checks;
  int failures;

  arbiter_wrr #(.REQ_WIDTH(4), .WGT_WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .weight  (weight),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] id_of(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic expect_gnt(input string tag, input logic [3:0] exp);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp));
    check({tag, ".id"}, 32'(gnt_id), 32'(id_of(exp)));
    check({tag, ".vld"}, 32'(gnt_vld), 32'(exp != 4'b0));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    tick();
    expect_gnt("reset", 4'b0000);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    weight   = '0;
    do_reset();

    // Idle: done ignored, nothing granted, base stays at channel 0
    done = 1'b1;
    tick(); expect_gnt("idle0", 4'b0000);
    tick(); expect_gnt("idle1", 4'b0000);
    done = 1'b0;

    // Round robin, all weights 1
    weight = 16'h1111;
    req    = 4'b1111;
    tick(); expect_gnt("rr0", 4'b0001);
    done = 1'b1;
    tick(); expect_gnt("rr1", 4'b0010);
    tick(); expect_gnt("rr2", 4'b0100);
    tick(); expect_gnt("rr3", 4'b1000);
    tick(); expect_gnt("rr4", 4'b0001);
    req = 4'b0000;
    tick(); expect_gnt("rr_idle", 4'b0000);
    done = 1'b0;

    // Weighted: channel 0 weight 3, channel 2 weight 1
    do_reset();
    weight = 16'h0103;
    req    = 4'b0101;
    tick(); expect_gnt("w_g0", 4'b0001);
    done = 1'b1;
    tick(); expect_gnt("w_d1", 4'b0001);
    tick(); expect_gnt("w_d2", 4'b0001);
    tick(); expect_gnt("w_d3", 4'b0100);
    tick(); expect_gnt("w_d4", 4'b0001);
    done = 1'b0;

    // Early release when the granted channel drops its request
    do_reset();
    weight = 16'h0050;
    req    = 4'b0010;
    tick(); expect_gnt("drop_g", 4'b0010);
    req = 4'b1001;
    tick(); expect_gnt("drop_hold", 4'b0010);
    done = 1'b1;
    tick(); expect_gnt("drop_rel", 4'b1000);
    done = 1'b0;

    // Grant locked without done while req changes
    do_reset();
    weight = 16'h1111;
    req    = 4'b0100;
    tick(); expect_gnt("lock_g", 4'b0100);
    for (int i = 0; i < 20; i++) begin
      req = 4'((i * 7) + 3);
      tick();
      check("lock_hold", 32'(gnt), 32'h4);
    end
    req  = 4'b1111;
    done = 1'b1;
    tick(); expect_gnt("lock_rel", 4'b1000);
    done = 1'b0;

    // Asynchronous reset mid-grant
    do_reset();
    weight = 16'h3000;
    req    = 4'b1000;
    tick(); expect_gnt("ar_g", 4'b1000);
    #2 rst_n = 1'b0;
    #1 expect_gnt("ar_async", 4'b0000);
    req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); expect_gnt("ar_first", 4'b0001);

    // Weight 0 acts as 1; lone requester re-granted every done
    do_reset();
    weight = 16'h0000;
    req    = 4'b1000;
    tick(); expect_gnt("w0_g", 4'b1000);
    done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_gnt("w0_regrant", 4'b1000);
    end
    done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
